// File: rtl/avg_pool_sequencer.sv
// Global average pool over 16 channels: accumulates N_ELEM samples per channel,
// scales by a reciprocal, then streams the 16 averages out as six write beats.
module avg_pool_sequencer #(
   parameter int N_ELEM = 49,
   parameter int RECIP  = 1337
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_valid,
   input  logic [15:0] i_data,
   output logic        o_ready,
   output logic [5:0]  o_opcode,
   output logic [47:0] o_wdata,
   output logic        o_wvalid,
   input  logic        i_wready,
   output logic        o_busy,
   output logic        o_done
);

   localparam int N_CH = 16;
   localparam int EW   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t             state_r;
   logic signed [21:0] acc_r;
   logic [EW-1:0]      elem_r;
   logic [3:0]         ch_r;
   logic [2:0]         beat_r;
   logic signed [15:0] buf_r [N_CH];

   logic               sample_acc_s;
   logic               beat_acc_s;
   logic               last_elem_s;
   logic               last_ch_s;
   logic               last_beat_s;
   logic signed [21:0] sum_s;
   logic signed [33:0] prod_s;
   logic signed [15:0] avg_s;
   logic [2:0]         next_beat_s;
   logic [47:0]        next_wdata_s;

   // Handshakes, running sum and the scaled (floor) average of the current channel
   always_comb begin
      sample_acc_s = i_valid && o_ready;
      beat_acc_s   = o_wvalid && i_wready;
      last_elem_s  = (elem_r == EW'(N_ELEM - 1));
      last_ch_s    = (ch_r == 4'd15);
      last_beat_s  = (beat_r == 3'd5);
      sum_s        = acc_r + {{6{i_data[15]}}, i_data};
      prod_s       = $signed({{12{sum_s[21]}}, sum_s}) * $signed(34'(RECIP));
      avg_s        = 16'(prod_s >>> 16);
   end

   // Beat to be loaded next: beat 0 when leaving ACCUM, otherwise the successor
   always_comb begin
      if (state_r == WRITE) begin
         next_beat_s = beat_r + 3'd1;
      end else begin
         next_beat_s = 3'd0;
      end
   end

   // Lane packing: three channels per beat, the last beat carries channel 15 alone
   always_comb begin
      next_wdata_s = 48'd0;
      case (next_beat_s)
         3'd0:    next_wdata_s = {buf_r[2],  buf_r[1],  buf_r[0]};
         3'd1:    next_wdata_s = {buf_r[5],  buf_r[4],  buf_r[3]};
         3'd2:    next_wdata_s = {buf_r[8],  buf_r[7],  buf_r[6]};
         3'd3:    next_wdata_s = {buf_r[11], buf_r[10], buf_r[9]};
         3'd4:    next_wdata_s = {buf_r[14], buf_r[13], buf_r[12]};
         3'd5:    next_wdata_s = {32'd0, buf_r[15]};
         default: next_wdata_s = 48'd0;
      endcase
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r  <= IDLE;
         acc_r    <= 22'sd0;
         elem_r   <= '0;
         ch_r     <= 4'd0;
         beat_r   <= 3'd0;
         o_ready  <= 1'b0;
         o_opcode <= 6'd0;
         o_wdata  <= 48'd0;
         o_wvalid <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            buf_r[i] <= 16'sd0;
         end
      end else begin
         o_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (i_start) begin
                  state_r <= ACCUM;
                  o_ready <= 1'b1;
                  o_busy  <= 1'b1;
                  acc_r   <= 22'sd0;
                  elem_r  <= '0;
                  ch_r    <= 4'd0;
               end
            end
            ACCUM: begin
               if (sample_acc_s) begin
                  if (last_elem_s) begin
                     buf_r[ch_r] <= avg_s;
                     acc_r       <= 22'sd0;
                     elem_r      <= '0;
                     if (last_ch_s) begin
                        state_r  <= WRITE;
                        ch_r     <= 4'd0;
                        beat_r   <= 3'd0;
                        o_ready  <= 1'b0;
                        o_wvalid <= 1'b1;
                        o_opcode <= 6'd32;
                        o_wdata  <= next_wdata_s;
                     end else begin
                        ch_r <= ch_r + 4'd1;
                     end
                  end else begin
                     acc_r  <= sum_s;
                     elem_r <= elem_r + EW'(1);
                  end
               end
            end
            WRITE: begin
               if (beat_acc_s) begin
                  if (last_beat_s) begin
                     state_r  <= IDLE;
                     beat_r   <= 3'd0;
                     o_wvalid <= 1'b0;
                     o_opcode <= 6'd0;
                     o_wdata  <= 48'd0;
                     o_busy   <= 1'b0;
                     o_done   <= 1'b1;
                  end else begin
                     beat_r   <= next_beat_s;
                     o_opcode <= 6'd32 + {3'd0, next_beat_s};
                     o_wdata  <= next_wdata_s;
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               o_ready  <= 1'b0;
               o_wvalid <= 1'b0;
               o_opcode <= 6'd0;
               o_wdata  <= 48'd0;
               o_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
